// File: rtl/me_frame_loader.sv
// ---------------------------------------------------------------------------
// me_frame_loader
//
// This is the front end of the motion-estimation datapath. It takes one frame
// job as a byte stream. The first RMEM_MAX bytes fill the 16x16 reference
// block and the next SMEM_MAX bytes fill the 32x32 search window. It then
// pulses `start` to the ME core and serves the core's three read ports. On
// `completed` it captures the core's result and offers it on a valid/ready
// port. When that result is taken, it goes back to loading the next job.
//
// Ports
//   clk, rst_n            single clock (posedge); async active-low reset
//   in_valid/in_ready     load byte handshake, in_data = byte
//   start                 one-cycle launch pulse to the ME core
//   completed             ME core done; BestDist/motionX/motionY are its result
//   AddressR              reference read address  -> R  (1-cycle latency)
//   AddressS1/AddressS2   search read addresses   -> S1/S2 (1-cycle latency)
//   res_valid/res_ready   result handshake; res_dist/res_mx/res_my = result
//   dbg_state             current FSM state (LOAD=0, START=1, RUN=2, RESULT=3)
//
// Handshake semantics (both in_* and res_*): a transfer happens on a rising
// clock edge where valid and ready are both high. The producer keeps valid and
// data stable until that edge. Ready never depends on valid in the same cycle.
// ---------------------------------------------------------------------------
module me_frame_loader #(
  parameter int RMEM_MAX = 256,
  parameter int SMEM_MAX = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       start,
  input  logic       completed,
  input  logic [7:0] BestDist,
  input  logic [3:0] motionX,
  input  logic [3:0] motionY,
  input  logic [7:0] AddressR,
  input  logic [9:0] AddressS1,
  input  logic [9:0] AddressS2,
  output logic [7:0] R,
  output logic [7:0] S1,
  output logic [7:0] S2,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_dist,
  output logic [3:0] res_mx,
  output logic [3:0] res_my,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [10:0] LD_LAST  = 11'(RMEM_MAX + SMEM_MAX - 1);
  localparam logic [10:0] R_BYTES  = 11'(RMEM_MAX);

  state_t      state;
  logic [10:0] ld_cnt;
  logic [9:0]  s_idx;
  logic        load_fire;

  logic [7:0] r_mem [RMEM_MAX];
  logic [7:0] s_mem [SMEM_MAX];

  // Only LOAD accepts bytes. in_valid in any other state is ignored.
  assign load_fire = in_valid && (state == ST_LOAD);
  // Search-window offset of the current load byte. It is only meaningful
  // once ld_cnt has passed the reference block.
  assign s_idx     = 10'(ld_cnt - R_BYTES);
  assign dbg_state = state;

  // Memory write port. The memories have no reset: their contents are only
  // defined once a load has written them.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (ld_cnt < R_BYTES) r_mem[ld_cnt[7:0]] <= in_data;
      else                  s_mem[s_idx]       <= in_data;
    end
  end

  // Read ports are always live. Reading an address that is being written in
  // the same cycle returns the old contents (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R  <= '0;
      S1 <= '0;
      S2 <= '0;
    end else begin
      R  <= r_mem[AddressR];
      S1 <= s_mem[AddressS1];
      S2 <= s_mem[AddressS2];
    end
  end

  // Control FSM. All of its outputs are registered and updated together with
  // the state. Because of that, in_ready is high exactly while the state is
  // LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      ld_cnt    <= '0;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      res_valid <= 1'b0;
      res_dist  <= '0;
      res_mx    <= '0;
      res_my    <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt   <= '0;
              state    <= ST_START;
              start    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              ld_cnt <= ld_cnt + 11'd1;
            end
          end
        end
        ST_START: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // completed is only looked at here. A level left high from the
          // previous job is therefore never captured while in LOAD.
          if (completed) begin
            res_dist  <= BestDist;
            res_mx    <= motionX;
            res_my    <= motionY;
            res_valid <= 1'b1;
            state     <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        default: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
